// File: rtl/bus_initiator.sv
// Single-transaction initiator for the peripheral memory bus.
// A client hands over one command at a time (valid/ready). The block runs one
// bus access, holding it until ready_in or until TIMEOUT expires, and then
// reports the result on a one-cycle response strobe.
//
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid_in / cmd_ready_out            client command handshake
//   cmd_address_in, cmd_write_mask_in,
//   cmd_write_value_in                      command payload (mask 0 = read)
//   rsp_valid_out, rsp_read_value_out,
//   rsp_error_out                           one-cycle response
//   busy_out                                high while a command is in flight
//   address_out, sel_out, write_mask_out,
//   write_value_out, read_value_in,
//   ready_in                                peripheral bus
module bus_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [31:0] cmd_address_in,
  input  logic [3:0]  cmd_write_mask_in,
  input  logic [31:0] cmd_write_value_in,
  output logic        rsp_valid_out,
  output logic [31:0] rsp_read_value_out,
  output logic        rsp_error_out,
  output logic        busy_out,
  output logic [31:0] address_out,
  output logic        sel_out,
  input  logic [31:0] read_value_in,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic        ready_in
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              sel_q, sel_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        mask_q, mask_d;
  logic [31:0]       wval_q, wval_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              timeout_hit;

  // Timeout only fires when enabled; completion is checked first in BUS.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = 1'b0;
    sel_d       = 1'b0;
    addr_d      = 32'd0;
    mask_d      = 4'd0;
    wval_d      = 32'd0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        // cmd_ready_q gates acceptance so nothing is taken on the first
        // edge after reset release.
        if (cmd_valid_in && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (cmd_address_in[1:0] != 2'b00) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = BUS;
            cnt_d   = '0;
            sel_d   = 1'b1;
            addr_d  = cmd_address_in;
            mask_d  = cmd_write_mask_in;
            wval_d  = cmd_write_value_in;
          end
        end
      end

      BUS: begin
        if (ready_in) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (mask_q == 4'd0) ? read_value_in : 32'd0;
        end else if (timeout_hit) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          // Hold the access stable until the responder answers.
          cnt_d  = cnt_q + CNT_W'(1);
          sel_d  = 1'b1;
          addr_d = addr_q;
          mask_d = mask_q;
          wval_d = wval_q;
        end
      end

      RESP: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      sel_q       <= 1'b0;
      addr_q      <= 32'd0;
      mask_q      <= 4'd0;
      wval_q      <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      wval_q      <= wval_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready_out      = cmd_ready_q;
  assign busy_out           = busy_q;
  assign sel_out            = sel_q;
  assign address_out        = addr_q;
  assign write_mask_out     = mask_q;
  assign write_value_out    = wval_q;
  assign rsp_valid_out      = rsp_valid_q;
  assign rsp_read_value_out = rsp_rdata_q;
  assign rsp_error_out      = rsp_err_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator (TIMEOUT = 4) with a programmable-wait responder.
module tb_bus_initiator;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid_in = 1'b0;
  logic        cmd_ready_out;
  logic [31:0] cmd_address_in = '0;
  logic [3:0]  cmd_write_mask_in = '0;
  logic [31:0] cmd_write_value_in = '0;
  logic        rsp_valid_out;
  logic [31:0] rsp_read_value_out;
  logic        rsp_error_out;
  logic        busy_out;
  logic [31:0] address_out;
  logic        sel_out;
  logic [31:0] read_value_in;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic        ready_in;

  bus_initiator #(.TIMEOUT(T)) dut (
    .clk                (clk),
    .reset              (reset),
    .cmd_valid_in       (cmd_valid_in),
    .cmd_ready_out      (cmd_ready_out),
    .cmd_address_in     (cmd_address_in),
    .cmd_write_mask_in  (cmd_write_mask_in),
    .cmd_write_value_in (cmd_write_value_in),
    .rsp_valid_out      (rsp_valid_out),
    .rsp_read_value_out (rsp_read_value_out),
    .rsp_error_out      (rsp_error_out),
    .busy_out           (busy_out),
    .address_out        (address_out),
    .sel_out            (sel_out),
    .read_value_in      (read_value_in),
    .write_mask_out     (write_mask_out),
    .write_value_out    (write_value_out),
    .ready_in           (ready_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Responder: ready on sel cycle number wait_n (0-based); -1 = never.
  int          wait_n = 0;
  logic [31:0] rd_val = '0;
  int          sel_cnt = 0;
  assign ready_in      = sel_out && (wait_n >= 0) && (sel_cnt == wait_n);
  assign read_value_in = rd_val;

  always @(posedge clk or negedge reset) begin
    if (!reset)                  sel_cnt <= 0;
    else if (sel_out && !ready_in) sel_cnt <= sel_cnt + 1;
    else                         sel_cnt <= 0;
  end

  // Vector: command, responder behaviour, and the required response.
  typedef struct {
    logic [31:0] a;
    logic [3:0]  m;
    logic [31:0] v;
    int          w;
    logic [31:0] rv;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;   // response cycle minus accept cycle
    int          exp_sels;  // cycles with sel_out high
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  m;
    logic [31:0] v;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          sels;
  } exp_t;

  exp_t sbq[$];
  int   sel_seen = 0;

  // Monitor: bus stability, idle-bus zeros, and response scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      sel_seen = 0;
    end else begin
      if (sel_out) begin
        sel_seen++;
        if (sbq.size() == 0) begin
          fail_now("unexpected_sel");
        end else begin
          chk("bus_addr", address_out, sbq[0].a);
          chk("bus_mask", 32'(write_mask_out), 32'(sbq[0].m));
          chk("bus_value", write_value_out, sbq[0].v);
          chk("bus_busy", 32'(busy_out), 32'd1);
        end
      end else begin
        chk("idle_bus_zero", address_out | write_value_out | 32'(write_mask_out), 32'd0);
      end
      if (rsp_valid_out) begin
        if (sbq.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rsp_rdata", rsp_read_value_out, e.rdata);
          chk("rsp_err", 32'(rsp_error_out), 32'(e.err));
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
          chk("sel_cycles", 32'(sel_seen), 32'(e.sels));
          chk("rsp_busy", 32'(busy_out), 32'd1);
        end
        sel_seen = 0;
      end
    end
  end

  function automatic exp_t mk_exp(input vec_t vv, input int acc);
    exp_t e;
    e.a     = vv.a;
    e.m     = vv.m;
    e.v     = vv.v;
    e.rdata = vv.exp_rdata;
    e.err   = vv.exp_err;
    e.cyc   = acc + vv.exp_lat;
    e.sels  = vv.exp_sels;
    return e;
  endfunction

  // Drive one command, wait for acceptance, push the expectation.
  task automatic issue(input vec_t vv);
    int guard;
    @(negedge clk);
    wait_n             = vv.w;
    rd_val             = vv.rv;
    cmd_valid_in       = 1'b1;
    cmd_address_in     = vv.a;
    cmd_write_mask_in  = vv.m;
    cmd_write_value_in = vv.v;
    guard = 0;
    while (!cmd_ready_out && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready_out) begin
      fail_now("accept_timeout");
      cmd_valid_in = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    sbq.push_back(mk_exp(vv, cyc));
    cmd_valid_in = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sbq.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() != 0) begin
      fail_now("rsp_timeout");
      sbq.delete();
    end
  endtask

  vec_t vecs[10];

  initial begin
    vec_t v1, v2;
    int   acc1, acc2, n;

    //        addr          mask     wdata         wait rdval         exp_rdata     err lat sels
    vecs[0] = '{32'h0000_0010, 4'hF, 32'h0000_0004,  0, 32'h1234_5678, 32'h0,        1'b0, 1, 1};
    vecs[1] = '{32'h0000_0020, 4'h0, 32'h0,          3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4, 4};
    vecs[2] = '{32'h0000_0030, 4'h3, 32'hAABB_CCDD, -1, 32'h0,        32'h0,        1'b1, 5, 5};
    vecs[3] = '{32'h0000_0034, 4'h0, 32'h0,          4, 32'h55AA_55AA, 32'h55AA_55AA, 1'b0, 5, 5};
    vecs[4] = '{32'h0000_0013, 4'hF, 32'h0000_0001,  0, 32'h0,        32'h0,        1'b1, 0, 0};
    vecs[5] = '{32'h0000_0002, 4'h0, 32'h0,          0, 32'h1111_1111, 32'h0,        1'b1, 0, 0};
    vecs[6] = '{32'h0000_0040, 4'h0, 32'h0,          0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1, 1};
    vecs[7] = '{32'hFFFF_FFFC, 4'h8, 32'h8000_0000,  2, 32'h9999_9999, 32'h0,        1'b0, 3, 3};
    vecs[8] = '{32'h0000_0044, 4'h0, 32'h0,         -1, 32'h0000_0077, 32'h0,        1'b1, 5, 5};
    vecs[9] = '{32'h0000_0048, 4'h5, 32'h0102_0304,  1, 32'h0,        32'h0,        1'b0, 2, 2};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready_out), 32'd0);
    chk("rst_sel", 32'(sel_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_out), 32'd0);
    chk("rst_rsp_err", 32'(rsp_error_out), 32'd0);
    chk("rst_rsp_rdata", rsp_read_value_out, 32'd0);
    chk("rst_bus", address_out | write_value_out | 32'(write_mask_out), 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_ready_before_clk", 32'(cmd_ready_out), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_ready_after_clk", 32'(cmd_ready_out), 32'd1);

    // Table-driven transactions.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i]);
      drain();
    end

    // Back-to-back writes with cmd_valid held high.
    v1 = '{32'h0000_0100, 4'hF, 32'h1111_1111, 0, 32'h0, 32'h0, 1'b0, 1, 1};
    v2 = '{32'h0000_0104, 4'h5, 32'h2222_2222, 0, 32'h0, 32'h0, 1'b0, 1, 1};
    issue(v1);
    acc1 = cyc - 0;
    cmd_valid_in       = 1'b1;
    cmd_address_in     = v2.a;
    cmd_write_mask_in  = v2.m;
    cmd_write_value_in = v2.v;
    @(negedge clk);
    n = 0;
    while (!cmd_ready_out && n < 20) begin
      chk("b2b_busy", 32'(busy_out), 32'd1);
      @(negedge clk);
      n++;
    end
    if (!cmd_ready_out) begin
      fail_now("b2b_accept_timeout");
      cmd_valid_in = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc2 = cyc;
      sbq.push_back(mk_exp(v2, acc2));
      cmd_valid_in = 1'b0;
      chk("b2b_period", 32'(acc2 - acc1), 32'd3);
    end
    drain();

    // Asynchronous reset while the bus access is pending.
    v1 = '{32'h0000_0200, 4'h0, 32'h0, -1, 32'h0, 32'h0, 1'b1, 5, 5};
    issue(v1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_sel", 32'(sel_out), 32'd0);
    chk("arst_busy", 32'(busy_out), 32'd0);
    chk("arst_rsp", 32'(rsp_valid_out), 32'd0);
    chk("arst_ready", 32'(cmd_ready_out), 32'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    issue(vecs[1]);
    drain();
    issue(vecs[0]);
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_initiator.md
Name: bus_initiator

Overview:
- Single-transaction initiator for the peripheral memory bus (address, sel, read value, write mask, write value, ready). It drives that bus toward responders such as the display and prescaler peripherals.
- A local client issues one command at a time through a valid/ready port. The block performs the bus access, holding it until ready or until timeout.
- It returns read data and a status on a one-cycle response strobe. Typical uses are self-test sequencers and boot-time register loaders that need to program peripherals without the CPU.

Parameters:
- TIMEOUT, default 255: maximum cycles sel_out is held waiting for ready_in. 0 disables the timeout (wait forever).

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset (low = reset asserted)
- cmd_valid_in  input  1  client command present
- cmd_ready_out  output  1  block can accept a command
- cmd_address_in  input  32  target bus address
- cmd_write_mask_in  input  4  byte-lane write enables; 4'b0000 = read
- cmd_write_value_in  input  32  write data
- rsp_valid_out  output  1  one-cycle response strobe
- rsp_read_value_out  output  32  read data (0 for writes and errors)
- rsp_error_out  output  1  qualifies rsp_valid_out: 1 = timeout or misaligned
- busy_out  output  1  high whenever state != IDLE
- address_out  output  32  bus address
- sel_out  output  1  bus select
- read_value_in  input  32  bus read data
- write_mask_out  output  4  bus write mask, passed through unchanged; no lane swapping
- write_value_out  output  32  bus write data
- ready_in  input  1  responder ready; may be combinational from sel_out

Behaviour:
- Reset values:
  - All outputs are driven to 0 while reset is low, except cmd_ready_out.
  - cmd_ready_out reads 0 while reset is low and goes to 1 on the first clk after release.
  - State = IDLE; timeout counter = 0.
- Reset mid-operation: sel_out drops asynchronously, the transaction is abandoned, and no response is produced.
- States: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_out = 1.
  - On cmd_valid_in && cmd_ready_out at edge N, the block registers address, mask and value.
  - If cmd_address_in[1:0] != 0, go to RESP with error = 1. No bus access occurs.
  - Otherwise go to BUS.
- BUS:
  - sel_out = 1, with address_out, write_mask_out and write_value_out held stable from the registered command. They must not change while sel_out is high.
  - Completion is the cycle where sel_out && ready_in. On that cycle:
    - capture read_value_in if the mask was 0, else capture 0;
    - error = 0;
    - go to RESP.
  - The counter increments each BUS cycle without ready_in.
  - When the counter == TIMEOUT (TIMEOUT != 0) and ready_in is low: capture read value 0, error = 1, go to RESP.
  - If ready_in arrives on the same cycle the timeout would fire, completion wins.
  - The counter clears on entering BUS. Counter width is clog2(TIMEOUT+1), minimum 1.
- RESP:
  - rsp_valid_out = 1 for exactly one cycle; sel_out = 0.
  - Then go to IDLE. No client backpressure on the response.
- Latency, with the command accepted at edge N:
  - sel_out high in cycle N+1.
  - Zero-wait responder: rsp_valid_out in cycle N+2.
  - Each responder wait cycle adds 1.
  - Misaligned command: rsp_valid_out in cycle N+1.
- Back-to-back commands: the next command is accepted at the earliest in the cycle after RESP (IDLE). Minimum command period is 3 cycles.
- Bus outputs when sel_out = 0: address, mask and value drive 0.
- cmd_*_in are ignored when cmd_ready_out = 0.

Test Plan:
1. Zero-wait write: cmd addr 0x0000_0010, mask 4'b1111, value 0x0000_0004, ready_in tied to sel_out. Required: sel_out high for exactly 1 cycle with address/mask/value as given; rsp_valid 2 cycles after accept; error 0, read value 0.
2. Read with 3 wait cycles: mask 0; responder asserts ready on the 4th sel cycle with read_value_in = 0xDEAD_BEEF. Required: sel_out high 4 cycles, inputs stable throughout; rsp_read_value 0xDEAD_BEEF, error 0.
3. Timeout with TIMEOUT=4: ready_in never asserted. Required: sel_out high for 5 cycles then low; rsp_valid with error 1, read value 0. Repeat with ready on the 5th sel cycle: success, error 0.
4. Misaligned: addr 0x0000_0013. Required: sel_out never asserts; rsp_valid 1 cycle after accept with error 1.
5. Back-to-back: cmd_valid held high with two queued writes to a zero-wait responder. Required: accepts 3 cycles apart; cmd_ready low while busy; each write appears once on the bus.
6. Async reset: pull reset low mid-BUS, between clock edges. Required: sel_out and busy drop immediately; no rsp_valid; the next command after release completes normally.
